// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA display register stage (address map, CTRL bits, default
// widths).
package vga_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_VAL_W  = 8;

    localparam logic [2:0] ADDR_VALUE     = 3'd0;
    localparam logic [2:0] ADDR_P1        = 3'd1;
    localparam logic [2:0] ADDR_P2        = 3'd2;
    localparam logic [2:0] ADDR_P3        = 3'd3;
    localparam logic [2:0] ADDR_P4        = 3'd4;
    localparam logic [2:0] ADDR_GAME_OVER = 3'd5;
    localparam logic [2:0] ADDR_CTRL      = 3'd6;
    localparam logic [2:0] ADDR_FRAME_CNT = 3'd7;

    localparam int unsigned CTRL_FORCE = 0;

    // p1..p4 and game_over live in one word array, indexed by (addr - ADDR_P1).
    localparam int unsigned NUM_WORDS = 5;

endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: single-flop falling-edge detector for a signal already in the clk domain.
module vga_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic fall_o
);

    logic low_q;
    logic low_d;

    // The flop holds "sig was low last cycle". Resetting it to 1 means a signal that is
    // already low when reset releases is not mistaken for a fresh falling edge.
    assign low_d = ~sig_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            low_q <= 1'b1;
        end else begin
            low_q <= low_d;
        end
    end

    assign fall_o = ~low_q & ~sig_i;

endmodule

// File: rtl/vga_display_regs.sv
// vga_display_regs: bus-written shadow registers for the VGA display variables, committed to the
// outputs on a vsync falling edge or a forced commit. Define VGA_FRAME_CNT_EN for the frame counter.
module vga_display_regs
    import vga_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned VAL_W  = DEF_VAL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_ack,
    input  logic              vsync,
    output logic [VAL_W-1:0]  value,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] game_over,
    output logic              frame_tick
);

    logic [VAL_W-1:0]  value_sh_q, value_sh_d;
    logic [DATA_W-1:0] word_sh_q  [NUM_WORDS];
    logic [DATA_W-1:0] word_sh_d  [NUM_WORDS];
    logic [VAL_W-1:0]  value_q, value_d;
    logic [DATA_W-1:0] word_out_q [NUM_WORDS];
    logic [DATA_W-1:0] word_out_d [NUM_WORDS];
    logic              dirty_q, dirty_d;
    logic              force_q, force_d;
    logic              wr_ack_q, wr_ack_d;
    logic              frame_tick_q, frame_tick_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              vsync_fall;
    logic              commit;
    logic [DATA_W-1:0] frame_cnt_rd;

    vga_edge_det u_vsync_fall (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (vsync),
        .fall_o (vsync_fall)
    );

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d  = commit ? frame_cnt_q + 16'd1 : frame_cnt_q;
    assign frame_cnt_rd = DATA_W'(frame_cnt_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign frame_cnt_rd = '0;
`endif

    // A force and a vsync edge in the same cycle collapse into one commit.
    assign commit = vsync_fall | force_q;

    always_comb begin
        value_sh_d   = value_sh_q;
        word_sh_d    = word_sh_q;
        value_d      = value_q;
        word_out_d   = word_out_q;
        dirty_d      = dirty_q;
        force_d      = 1'b0;
        wr_ack_d     = wr_en;
        frame_tick_d = commit;

        // Commit reads the current shadows, so a same-cycle write waits for the next frame.
        if (commit) begin
            dirty_d = 1'b0;
            if (dirty_q) begin
                value_d    = value_sh_q;
                word_out_d = word_sh_q;
            end
        end

        if (wr_en) begin
            unique case (addr)
                ADDR_VALUE: begin
                    value_sh_d = wr_data[VAL_W-1:0];
                    dirty_d    = 1'b1;
                end
                ADDR_P1, ADDR_P2, ADDR_P3, ADDR_P4, ADDR_GAME_OVER: begin
                    word_sh_d[3'(addr - ADDR_P1)] = wr_data;
                    dirty_d                       = 1'b1;
                end
                ADDR_CTRL:      force_d = wr_data[CTRL_FORCE];
                ADDR_FRAME_CNT: ;
                default:        ;
            endcase
        end

        unique case (addr)
            ADDR_VALUE:     rd_data_d = DATA_W'(value_sh_q);
            ADDR_P1, ADDR_P2, ADDR_P3, ADDR_P4, ADDR_GAME_OVER:
                            rd_data_d = word_sh_q[3'(addr - ADDR_P1)];
            ADDR_CTRL:      rd_data_d = DATA_W'(dirty_q);
            ADDR_FRAME_CNT: rd_data_d = frame_cnt_rd;
            default:        rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_sh_q   <= '0;
            word_sh_q    <= '{default: '0};
            value_q      <= '0;
            word_out_q   <= '{default: '0};
            dirty_q      <= 1'b0;
            force_q      <= 1'b0;
            wr_ack_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            value_sh_q   <= value_sh_d;
            word_sh_q    <= word_sh_d;
            value_q      <= value_d;
            word_out_q   <= word_out_d;
            dirty_q      <= dirty_d;
            force_q      <= force_d;
            wr_ack_q     <= wr_ack_d;
            frame_tick_q <= frame_tick_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign value      = value_q;
    assign p1         = word_out_q[0];
    assign p2         = word_out_q[1];
    assign p3         = word_out_q[2];
    assign p4         = word_out_q[3];
    assign game_over  = word_out_q[4];
    assign wr_ack     = wr_ack_q;
    assign frame_tick = frame_tick_q;
    assign rd_data    = rd_data_q;

endmodule
